// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a small byte FIFO feeding an 8N1 serialiser with internal baud timing.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1 frames).
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 2
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_en,
    output logic       tx_full,
    output logic       tx_idle,
    output logic       tx_ovf,
    output logic       UART_TX
);

    localparam int                DEPTH    = 1 << FIFO_AW;
    localparam int                CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]     LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0]  FULL_CNT = (FIFO_AW + 1)'(DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      baud_cnt;
    logic [7:0]         shift;
    logic [7:0]         shift_nxt;
    logic [2:0]         bit_idx;
    logic [2:0]         bit_idx_nxt;
    logic               tx_nxt;
    logic               push;
    logic               pop;
    logic               bit_done;
`ifdef UART_TX_PARITY_EN
    logic               parity;
`endif

    assign push     = tx_en && !tx_full;
    assign bit_done = (baud_cnt == LAST_CNT);
    assign tx_full  = (count == FULL_CNT);
    assign tx_idle  = (count == '0) && (state == S_IDLE);

    // NOTE: every signal gets a default before the case, so no path leaves one unassigned (no latches).
    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift;
        bit_idx_nxt = bit_idx;
        pop         = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    pop         = 1'b1;
                    shift_nxt   = mem[rd_ptr];
                    bit_idx_nxt = '0;
                    state_nxt   = S_START;
                end
            end
            S_START: begin
                if (bit_done) state_nxt = S_DATA;
            end
            S_DATA: begin
                if (bit_done) begin
                    shift_nxt   = {1'b0, shift[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = S_PARITY;
`else
                        state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_done) state_nxt = S_STOP;
            end
`endif
            S_STOP: begin
                // Chain straight into the next start bit so queued frames stay contiguous.
                if (bit_done) begin
                    if (count != '0) begin
                        pop         = 1'b1;
                        shift_nxt   = mem[rd_ptr];
                        bit_idx_nxt = '0;
                        state_nxt   = S_START;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Line level is decoded from the next state so UART_TX itself can be a flop.
    always_comb begin
        tx_nxt = 1'b1;
        case (state_nxt)
            S_START:  tx_nxt = 1'b0;
            S_DATA:   tx_nxt = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_nxt = parity;
`endif
            default:  tx_nxt = 1'b1;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of order.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            shift    <= '0;
            bit_idx  <= '0;
            UART_TX  <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            tx_ovf   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            shift   <= shift_nxt;
            bit_idx <= bit_idx_nxt;
            UART_TX <= tx_nxt;

            if (state == S_IDLE || bit_done) baud_cnt <= '0;
            else                             baud_cnt <= baud_cnt + 1'b1;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;

            if (tx_en && tx_full) tx_ovf <= 1'b1;
`ifdef UART_TX_PARITY_EN
            if (pop) parity <= ^mem[rd_ptr];
`endif
        end
    end

    // NOTE: FIFO storage is not reset; the count and pointers alone decide which entries are valid.
    always_ff @(posedge sysclk) begin
        if (push) mem[wr_ptr] <= tx_data;
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: a line monitor decodes frames and compares them with queued bytes.
module tb_uart_tx_buffered;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CYC = NBITS * CPB;

    logic       sysclk = 1'b0;
    logic       reset  = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_en  = 1'b0;
    logic       tx_full;
    logic       tx_idle;
    logic       tx_ovf;
    logic       UART_TX;

    typedef struct {
        logic [7:0] data;
        bit         b2b;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 sysclk = ~sysclk;

    uart_tx_buffered #(
        .CLKS_PER_BIT(CPB),
        .FIFO_AW     (2)
    ) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .tx_data(tx_data),
        .tx_en  (tx_en),
        .tx_full(tx_full),
        .tx_idle(tx_idle),
        .tx_ovf (tx_ovf),
        .UART_TX(UART_TX)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one byte for exactly one rising edge; optionally record it as an expected frame.
    task automatic push(input logic [7:0] d, input bit expect_tx, input bit b2b);
        exp_t e;
        @(negedge sysclk);
        tx_en   = 1'b1;
        tx_data = d;
        if (expect_tx) begin
            e.data = d;
            e.b2b  = b2b;
            sb.push_back(e);
        end
        @(posedge sysclk);
        #1;
        tx_en   = 1'b0;
        tx_data = 8'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge sysclk);
            n++;
        end while (!tx_idle && n < budget);
        if (!tx_idle) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: tx_idle still 0 after %0d cycles, expected 1", budget);
        end
        repeat (2) @(negedge sysclk);
    endtask

    // Line monitor
    logic             mon_active = 1'b0;
    logic             mon_ended  = 1'b0;
    logic             mon_glitch = 1'b0;
    int               mon_cyc    = 0;
    logic [NBITS-1:0] mon_bits   = '0;

    task automatic finish_frame();
        exp_t       e;
        logic [7:0] d;
        d = mon_bits[8:1];
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_frame: got frame with data 0x%02h, expected no frame", d);
        end else begin
            e = sb.pop_front();
            check("frame_data", d, e.data);
            check("stop_bit", mon_bits[NBITS-1], 1);
            check("bit_timing", mon_glitch, 0);
`ifdef UART_TX_PARITY_EN
            check("parity_bit", mon_bits[9], ^e.data);
`endif
        end
    endtask

    always @(negedge sysclk) begin
        if (reset) begin
            mon_active = 1'b0;
            mon_ended  = 1'b0;
        end else if (mon_active) begin
            mon_cyc++;
            if (mon_cyc % CPB == 0) mon_bits[mon_cyc / CPB] = UART_TX;
            else if (UART_TX !== mon_bits[mon_cyc / CPB]) mon_glitch = 1'b1;
            if (mon_cyc == FRAME_CYC - 1) begin
                finish_frame();
                mon_active = 1'b0;
                mon_ended  = 1'b1;
            end
        end else begin
            if (mon_ended && sb.size() > 0 && sb[0].b2b) check("b2b_gap", UART_TX, 0);
            mon_ended = 1'b0;
            if (UART_TX === 1'b0) begin
                mon_active = 1'b1;
                mon_cyc    = 0;
                mon_bits   = '0;
                mon_glitch = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state and quiet line
        repeat (3) @(negedge sysclk);
        check("rst_line", UART_TX, 1);
        check("rst_idle", tx_idle, 1);
        check("rst_full", tx_full, 0);
        check("rst_ovf", tx_ovf, 0);
        #2 reset = 1'b0;
        repeat (100) begin
            @(negedge sysclk);
            check("quiet_after_reset", {UART_TX, tx_idle, tx_full, tx_ovf}, 4'b1100);
        end

        // Single byte: start bit two edges after the push, idle again one frame later
        push(8'hA5, 1'b1, 1'b0);
        @(negedge sysclk);
        check("pre_start_line", UART_TX, 1);
        check("idle_fall", tx_idle, 0);
        @(negedge sysclk);
        check("start_latency", UART_TX, 0);
        repeat (FRAME_CYC - 1) @(negedge sysclk);
        check("idle_before_end", tx_idle, 0);
        @(negedge sysclk);
        check("idle_rise", tx_idle, 1);
        wait_done(20);

        // Five consecutive pushes fill the FIFO, then two rejected pushes
        for (int i = 1; i <= 5; i++) begin
            push(8'(i), 1'b1, (i > 1));
            if (i == 4) check("full_at_3", tx_full, 0);
            if (i == 5) check("full_at_4", tx_full, 1);
        end
        check("ovf_before", tx_ovf, 0);
        push(8'h06, 1'b0, 1'b0);
        check("ovf_set", tx_ovf, 1);
        push(8'h07, 1'b0, 1'b0);
        wait_done(400);
        check("ovf_sticky", tx_ovf, 1);
        check("sb_drained", sb.size(), 0);

        // Reset in the middle of 0x3C's data bits with two bytes queued
        push(8'h3C, 1'b0, 1'b0);
        push(8'h11, 1'b0, 1'b0);
        push(8'h22, 1'b0, 1'b0);
        repeat (5) @(negedge sysclk);
        check("mid_data_line", UART_TX, 0);
        #2 reset = 1'b1;
        #1;
        check("abort_line", UART_TX, 1);
        check("abort_idle", tx_idle, 1);
        check("abort_full", tx_full, 0);
        check("abort_ovf", tx_ovf, 0);
        @(negedge sysclk);
        @(negedge sysclk);
        #2 reset = 1'b0;
        repeat (100) begin
            @(negedge sysclk);
            check("quiet_after_abort", {UART_TX, tx_idle, tx_full, tx_ovf}, 4'b1100);
        end

        // Parity patterns (odd and even number of ones)
        push(8'h07, 1'b1, 1'b0);
        wait_done(100);
        push(8'h03, 1'b1, 1'b0);
        wait_done(100);
        check("sb_empty_final", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
